// File: rtl/tile_repack_buffer.sv
// tile_repack_buffer
// Byte-addressable ROWS x COLS tile store that streams its contents back out
// as PACK-element words over a valid/ready handshake, with a one-cycle done
// pulse after the final word is accepted.
// Optional feature: define TILE_REPACK_TRANSPOSE_EN to add the `transpose`
// input, which selects column-major readout packed down rows.
module tile_repack_buffer #(
    parameter int DW   = 8,
    parameter int PACK = 2,
    parameter int ROWS = 8,
    parameter int COLS = 8,
    localparam int RW  = $clog2(ROWS),
    localparam int CW  = $clog2(COLS),
    localparam int NW  = ROWS * COLS / PACK,
    localparam int OW  = DW * PACK,
    localparam int IW  = $clog2(NW)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
`ifdef TILE_REPACK_TRANSPOSE_EN
    input  logic          transpose,
`endif
    input  logic          wr_en,
    input  logic [RW-1:0] wr_row,
    input  logic [CW-1:0] wr_col,
    input  logic [DW-1:0] wr_data,
    output logic          wr_err,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic [IW-1:0] out_idx,
    output logic          busy,
    output logic          done
);

    // Words per row (row-major) and words per column (column-major).
    localparam int WPR = COLS / PACK;
    localparam int WPC = ROWS / PACK;

    localparam logic [RW:0]   ROWS_L   = (RW + 1)'(ROWS);
    localparam logic [CW:0]   COLS_L   = (CW + 1)'(COLS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;

    logic [DW-1:0]   mem_r [ROWS][COLS];

    logic            wr_ok_s;
    logic            load_en_s;
    logic [IW-1:0]   load_idx_s;
    logic [OW-1:0]   word_s;
    logic            tr_sel_s;

    logic            wr_err_r;
    logic            out_valid_r;
    logic [OW-1:0]   out_data_r;
    logic [IW-1:0]   out_idx_r;
    logic            busy_r;
    logic            done_r;

`ifdef TILE_REPACK_TRANSPOSE_EN
    logic            transpose_r;

    // Orientation: live input while a start can be accepted, latched copy afterwards.
    always_comb begin
        tr_sel_s = (state_r == ST_IDLE) ? transpose : transpose_r;
    end

    // Capture the orientation of the readout when start is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            transpose_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            transpose_r <= transpose;
        end else begin
            transpose_r <= transpose_r;
        end
    end
`else
    // Row-major readout only.
    always_comb begin
        tr_sel_s = 1'b0;
    end
`endif

    // A write commits only while idle/done and with an in-range index.
    always_comb begin
        wr_ok_s = wr_en && !busy_r
                  && ({1'b0, wr_row} < ROWS_L)
                  && ({1'b0, wr_col} < COLS_L);
    end

    // Tile storage; deliberately not reset so contents survive a reset.
    always_ff @(posedge clock) begin
        if (wr_ok_s) begin
            mem_r[wr_row][wr_col] <= wr_data;
        end else begin
            mem_r[wr_row][wr_col] <= mem_r[wr_row][wr_col];
        end
    end

    // Gather the PACK elements of word load_idx_s, lowest element in the MSBs.
    always_comb begin : word_mux
        logic [RW-1:0] r_v;
        logic [CW-1:0] c_v;
        word_s = '0;
        r_v    = '0;
        c_v    = '0;
        for (int p = 0; p < PACK; p++) begin
            if (tr_sel_s) begin
                c_v = CW'(load_idx_s / WPC);
                r_v = RW'((load_idx_s % WPC) * PACK + p);
            end else begin
                r_v = RW'(load_idx_s / WPR);
                c_v = CW'((load_idx_s % WPR) * PACK + p);
            end
            word_s[OW - 1 - p * DW -: DW] = mem_r[r_v][c_v];
        end
    end

    // Next-state logic and selection of the next word to present.
    always_comb begin
        state_nx_s = state_r;
        load_en_s  = 1'b0;
        load_idx_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_SEND;
                    load_en_s  = 1'b1;
                    load_idx_s = '0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (out_idx_r == LAST_IDX) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        load_en_s  = 1'b1;
                        load_idx_s = out_idx_r + IW'(1);
                    end
                end else begin
                    state_nx_s = ST_SEND;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered outputs, all derived from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
            wr_err_r    <= 1'b0;
            out_data_r  <= '0;
            out_idx_r   <= '0;
        end else begin
            state_r     <= state_nx_s;
            busy_r      <= (state_nx_s == ST_SEND);
            out_valid_r <= (state_nx_s == ST_SEND);
            done_r      <= (state_nx_s == ST_DONE);
            wr_err_r    <= wr_en && busy_r;
            if (load_en_s) begin
                out_data_r <= word_s;
                out_idx_r  <= load_idx_s;
            end else begin
                out_data_r <= out_data_r;
                out_idx_r  <= out_idx_r;
            end
        end
    end

    assign wr_err    = wr_err_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_idx   = out_idx_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_tile_repack_buffer.sv
// Directed self-checking bench for tile_repack_buffer at default parameters.
// The tile is preloaded with mem[r][c] = 8r+c before any readout.
module tb_tile_repack_buffer;

    localparam int NW_TB = 32;

    logic        clock;
    logic        reset;
    logic        start;
`ifdef TILE_REPACK_TRANSPOSE_EN
    logic        transpose;
`endif
    logic        wr_en;
    logic [2:0]  wr_row;
    logic [2:0]  wr_col;
    logic [7:0]  wr_data;
    logic        wr_err;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [4:0]  out_idx;
    logic        busy;
    logic        done;

    int check_cnt;
    int err_cnt;

    tile_repack_buffer dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
`ifdef TILE_REPACK_TRANSPOSE_EN
        .transpose (transpose),
`endif
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .wr_err    (wr_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    // 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected word k for the 8r+c tile pattern.
    function automatic logic [15:0] exp_word(input int k, input bit tr);
        int r;
        int c;
        if (!tr) begin
            r = k / 4;
            c = 2 * (k % 4);
            return {8'(8 * r + c), 8'(8 * r + c + 1)};
        end else begin
            c = k / 4;
            r = 2 * (k % 4);
            return {8'(8 * r + c), 8'(8 * r + 8 + c)};
        end
    endfunction

    // poke_kind: 0 none, 1 start pulse at word poke_idx and during DONE,
    // 2 write to (0,0) at word poke_idx.
    task automatic read_tile(input bit tr, input int stall_idx, input int stall_len,
                             input int poke_idx, input int poke_kind);
        logic [15:0] exp_w;
        start     = 1'b1;
        out_ready = 1'b1;
`ifdef TILE_REPACK_TRANSPOSE_EN
        transpose = tr;
`endif
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < NW_TB; k++) begin
            exp_w = exp_word(k, tr);
            check_eq("out_valid", 32'(out_valid), 32'd1);
            check_eq("out_idx", 32'(out_idx), 32'(k));
            check_eq("out_data", 32'(out_data), 32'(exp_w));
            check_eq("busy", 32'(busy), 32'd1);
            check_eq("done_low", 32'(done), 32'd0);
            check_eq("wr_err", 32'(wr_err), 32'((poke_kind == 2) && (k == poke_idx + 1)));
            if (!tr && k == 0)  check_eq("first_word", 32'(out_data), 32'h0001);
            if (!tr && k == 31) check_eq("last_word", 32'(out_data), 32'h3E3F);
            if (tr && k == 1)   check_eq("tr_word1", 32'(out_data), 32'h1018);
            if (tr && k == 31)  check_eq("tr_last", 32'(out_data), 32'h373F);
            if (k == poke_idx && poke_kind == 1) begin
                start = 1'b1;
            end else if (k == poke_idx && poke_kind == 2) begin
                wr_en   = 1'b1;
                wr_row  = 3'd0;
                wr_col  = 3'd0;
                wr_data = 8'hFF;
            end
            if (k == stall_idx) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clock);
                    check_eq("hold_data", 32'(out_data), 32'(exp_w));
                    check_eq("hold_valid", 32'(out_valid), 32'd1);
                    check_eq("hold_idx", 32'(out_idx), 32'(k));
                end
                out_ready = 1'b1;
            end
            @(negedge clock);
            start = 1'b0;
            wr_en = 1'b0;
        end
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("done_busy", 32'(busy), 32'd0);
        check_eq("done_valid", 32'(out_valid), 32'd0);
        if (poke_kind == 1) start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_eq("idle_done", 32'(done), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        check_eq("no_restart", 32'(busy), 32'd0);
    endtask

    initial begin
        check_cnt = 0;
        err_cnt   = 0;
        reset     = 1'b1;
        start     = 1'b0;
`ifdef TILE_REPACK_TRANSPOSE_EN
        transpose = 1'b0;
`endif
        wr_en     = 1'b0;
        wr_row    = 3'd0;
        wr_col    = 3'd0;
        wr_data   = 8'd0;
        out_ready = 1'b1;

        // Reset state.
        repeat (3) @(negedge clock);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_idx", 32'(out_idx), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_wr_err", 32'(wr_err), 32'd0);
        reset = 1'b0;

        // Preload mem[r][c] = 8r+c.
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                wr_en   = 1'b1;
                wr_row  = 3'(r);
                wr_col  = 3'(c);
                wr_data = 8'(8 * r + c);
                @(negedge clock);
            end
        end
        wr_en = 1'b0;

        // Free-flowing readout.
        read_tile(1'b0, -1, 0, -1, 0);

        // Backpressure: 3 stall cycles while word 5 (0x0A0B) is presented.
        read_tile(1'b0, 5, 3, -1, 0);

        // Write while busy is rejected with a wr_err pulse.
        read_tile(1'b0, -1, 0, 4, 2);
        read_tile(1'b0, -1, 0, -1, 0);

        // Reset mid-stream at word 10.
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        check_eq("pre_rst_idx", 32'(out_idx), 32'd10);
        check_eq("pre_rst_data", 32'(out_data), 32'h1415);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_data", 32'(out_data), 32'd0);
        check_eq("mid_rst_idx", 32'(out_idx), 32'd0);
        read_tile(1'b0, -1, 0, -1, 0);

        // Start ignored during SEND (word 3) and during DONE.
        read_tile(1'b0, -1, 0, 3, 1);

`ifdef TILE_REPACK_TRANSPOSE_EN
        // Column-major readout, then a plain row-major one.
        read_tile(1'b1, -1, 0, -1, 0);
        read_tile(1'b0, -1, 0, -1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
